// File: rtl/hwint_pkg.sv
// Purpose: shared register offsets, mode encodings and helpers for the interrupt controller.
// Latency: n/a (constants and combinational helpers only).
// Backpressure: n/a.
package hwint_pkg;

    localparam logic [3:0] HWINT_ENABLE  = 4'h0;
    localparam logic [3:0] HWINT_MODE    = 4'h4;
    localparam logic [3:0] HWINT_PENDING = 4'h8;
    localparam logic [3:0] HWINT_RAW     = 4'hC;

    localparam logic MODE_EDGE  = 1'b1;
    localparam logic MODE_LEVEL = 1'b0;

    // Register writes are only honoured for full-word accesses.
    function automatic logic full_word(input logic [3:0] byteen);
        return byteen == 4'b1111;
    endfunction

endpackage

// File: rtl/hwint_sync.sv
// Purpose: multi-flop synchroniser for a bus of independent asynchronous lines.
// Latency: STAGES clocks from input change to output.
// Backpressure: none; samples every clock.
module hwint_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift chain; cleared by reset regardless of the raw inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/hwint_ctrl.sv
// Purpose: interrupt controller: per-source edge/level mode, enable mask, W1C pending, register file.
// Latency: level input to hwint SYNC_STAGES+1 clks, edge SYNC_STAGES+2; register read 1 clk.
// Backpressure: none; register accesses complete every cycle, pending holds edges until cleared.
module hwint_ctrl
    import hwint_pkg::*;
#(
    parameter int N_SRC       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  irq_in,
    input  logic              reg_we,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [3:0]        reg_byteen,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic [N_SRC-1:0]  hwint,
    output logic              irq_any
);

    localparam logic [ADDR_W-1:0] A_ENABLE  = ADDR_W'(HWINT_ENABLE);
    localparam logic [ADDR_W-1:0] A_MODE    = ADDR_W'(HWINT_MODE);
    localparam logic [ADDR_W-1:0] A_PENDING = ADDR_W'(HWINT_PENDING);
    localparam logic [ADDR_W-1:0] A_RAW     = ADDR_W'(HWINT_RAW);

    logic [N_SRC-1:0] sync_lvl;
    logic [N_SRC-1:0] prev_lvl;
    logic [N_SRC-1:0] enable;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] src;
    logic [N_SRC-1:0] pending_nxt;
    logic [31:0]      rd_mux;
    logic             wr_ok;
    logic             wdata_unused;

    assign wdata_unused = ^reg_wdata[31:N_SRC];

    hwint_sync #(
        .WIDTH  (N_SRC),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (irq_in),
        .q     (sync_lvl)
    );

    // Edge detect, source select, read mux and pending next-state; a new rise beats a same-cycle W1C.
    always_comb begin
        rise        = sync_lvl & ~prev_lvl;
        wr_ok       = reg_we && full_word(reg_byteen);
        src         = '0;
        rd_mux      = '0;
        pending_nxt = pending;
        for (int i = 0; i < N_SRC; i++) begin
            src[i] = (mode[i] == MODE_EDGE) ? pending[i] : sync_lvl[i];
        end
        case (reg_addr)
            A_ENABLE:  rd_mux = 32'(enable);
            A_MODE:    rd_mux = 32'(mode);
            A_PENDING: rd_mux = 32'(pending);
            A_RAW:     rd_mux = 32'(sync_lvl);
            default:   rd_mux = '0;
        endcase
        if (wr_ok && reg_addr == A_PENDING) begin
            pending_nxt = pending & ~reg_wdata[N_SRC-1:0];
        end
        pending_nxt = pending_nxt | (rise & mode);
    end

    // Control registers, edge history and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_lvl  <= '0;
            enable    <= '0;
            mode      <= '0;
            pending   <= '0;
            hwint     <= '0;
            irq_any   <= 1'b0;
            reg_rdata <= '0;
        end else begin
            prev_lvl <= sync_lvl;
            if (wr_ok && reg_addr == A_ENABLE) enable <= reg_wdata[N_SRC-1:0];
            if (wr_ok && reg_addr == A_MODE)   mode   <= reg_wdata[N_SRC-1:0];
            pending   <= pending_nxt;
            hwint     <= src & enable;
            irq_any   <= |(src & enable);
            reg_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_hwint_ctrl.sv
module tb_hwint_ctrl;

    localparam int N   = 6;
    localparam int STG = 2;
    localparam int AW  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  irq_in;
    logic          reg_we;
    logic [AW-1:0] reg_addr;
    logic [3:0]    reg_byteen;
    logic [31:0]   reg_wdata;
    logic [31:0]   reg_rdata;
    logic [N-1:0]  hwint;
    logic          irq_any;

    always #5 clk = ~clk;

    hwint_ctrl #(.N_SRC(N), .SYNC_STAGES(STG), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_byteen (reg_byteen),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .hwint      (hwint),
        .irq_any    (irq_any)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural reference: synchroniser as a delay line of sampled inputs.
    logic [N-1:0] m_line [STG];
    logic [N-1:0] m_prev, m_en, m_mode, m_pend, m_hw;
    logic         m_any;
    logic [31:0]  m_rd;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < STG; i++) m_line[i] = '0;
        m_prev = '0; m_en = '0; m_mode = '0; m_pend = '0; m_hw = '0; m_any = 1'b0; m_rd = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] s, src, npend;
        logic         full;
        if (!reset) begin
            model_clear();
            return;
        end
        s    = m_line[STG-1];
        full = reg_we && (reg_byteen == 4'hF);
        for (int i = 0; i < N; i++) begin
            src[i] = m_mode[i] ? m_pend[i] : s[i];
            if (m_mode[i] && s[i] && !m_prev[i])                       npend[i] = 1'b1;
            else if (full && reg_addr == 5'h08 && reg_wdata[i])        npend[i] = 1'b0;
            else                                                       npend[i] = m_pend[i];
        end
        case (reg_addr)
            5'h00:   m_rd = {26'd0, m_en};
            5'h04:   m_rd = {26'd0, m_mode};
            5'h08:   m_rd = {26'd0, m_pend};
            5'h0C:   m_rd = {26'd0, s};
            default: m_rd = 32'd0;
        endcase
        m_hw  = src & m_en;
        m_any = (m_hw != 0);
        if (full && reg_addr == 5'h00) m_en   = reg_wdata[N-1:0];
        if (full && reg_addr == 5'h04) m_mode = reg_wdata[N-1:0];
        m_pend = npend;
        m_prev = s;
        for (int i = STG - 1; i > 0; i--) m_line[i] = m_line[i-1];
        m_line[0] = irq_in;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d; reg_byteen = be;
        cyc();
        reg_we = 1'b0; reg_byteen = 4'hF;
    endtask

    task automatic rd(input logic [AW-1:0] a, input string name, input logic [31:0] exp);
        reg_addr = a;
        cyc();
        chk(name, reg_rdata, exp);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'h00, 4'hF, 32'h15,       32'h00};
        tbl[1]  = '{1'b0, 5'h00, 4'hF, 32'h0,        32'h15};
        tbl[2]  = '{1'b1, 5'h00, 4'h3, 32'h3F,       32'h15};
        tbl[3]  = '{1'b0, 5'h00, 4'hF, 32'h0,        32'h15};
        tbl[4]  = '{1'b1, 5'h04, 4'hF, 32'h2A,       32'h00};
        tbl[5]  = '{1'b0, 5'h04, 4'hF, 32'h0,        32'h2A};
        tbl[6]  = '{1'b1, 5'h0C, 4'hF, 32'h3F,       32'h00};
        tbl[7]  = '{1'b0, 5'h0C, 4'hF, 32'h0,        32'h00};
        tbl[8]  = '{1'b1, 5'h10, 4'hF, 32'hFF,       32'h00};
        tbl[9]  = '{1'b0, 5'h10, 4'hF, 32'h0,        32'h00};
        tbl[10] = '{1'b0, 5'h00, 4'hF, 32'h0,        32'h15};
        tbl[11] = '{1'b1, 5'h00, 4'hF, 32'hFFFFFFFF, 32'h15};
        tbl[12] = '{1'b0, 5'h00, 4'hF, 32'h0,        32'h3F};
        tbl[13] = '{1'b0, 5'h00, 4'hF, 32'h0,        32'h3F};
        tbl[14] = '{1'b0, 5'h00, 4'hF, 32'h0,        32'h3F};
        tbl[15] = '{1'b1, 5'h00, 4'hF, 32'h0,        32'h3F};
        tbl[16] = '{1'b1, 5'h04, 4'hF, 32'h0,        32'h2A};
        tbl[17] = '{1'b0, 5'h04, 4'hF, 32'h0,        32'h00};
        tbl[18] = '{1'b1, 5'h02, 4'hF, 32'h3F,       32'h00};
        tbl[19] = '{1'b0, 5'h00, 4'hF, 32'h0,        32'h00};

        reset = 1'b0; irq_in = '0; reg_we = 1'b0; reg_addr = 5'h0C;
        reg_byteen = 4'hF; reg_wdata = '0;
        model_clear();

        // Reset held with toggling inputs
        for (int i = 0; i < 4; i++) begin
            irq_in = (i % 2 == 0) ? 6'h3F : 6'h00;
            cyc();
            chk("rst_hwint", hwint, 0);
            chk("rst_any", irq_any, 0);
            chk("rst_rdata", reg_rdata, 0);
        end
        irq_in = '0;
        reset = 1'b1;
        cyc(); cyc(); cyc();
        rd(5'h00, "rst_enable", 0);
        rd(5'h04, "rst_mode", 0);
        rd(5'h08, "rst_pending", 0);

        // Register-access table
        for (int i = 0; i < 20; i++) begin
            reg_we = tbl[i].we; reg_addr = tbl[i].addr;
            reg_byteen = tbl[i].be; reg_wdata = tbl[i].wd;
            cyc();
            chk($sformatf("tbl%0d_rdata", i), reg_rdata, tbl[i].exp);
            chk($sformatf("tbl%0d_hwint", i), hwint, 0);
        end
        reg_we = 1'b0; reg_byteen = 4'hF;

        // Level mode
        wr(5'h00, 32'h01, 4'hF);
        irq_in = 6'h01;
        cyc(); cyc();
        chk("lvl_early", hwint, 0);
        cyc();
        chk("lvl_assert", hwint, 6'h01);
        chk("lvl_any", irq_any, 1);
        irq_in = 6'h00;
        cyc(); cyc();
        chk("lvl_hold", hwint, 6'h01);
        cyc();
        chk("lvl_deassert", hwint, 0);
        chk("lvl_any_off", irq_any, 0);
        wr(5'h00, 32'h0, 4'hF);

        // Edge mode with W1C
        wr(5'h04, 32'h02, 4'hF);
        wr(5'h00, 32'h02, 4'hF);
        irq_in = 6'h02;
        cyc(); cyc();
        irq_in = 6'h00;
        cyc();
        chk("edge_early", hwint, 0);
        cyc();
        chk("edge_assert", hwint, 6'h02);
        cyc(); cyc(); cyc();
        chk("edge_sticky", hwint, 6'h02);
        wr(5'h08, 32'h02, 4'hF);
        chk("edge_w1c_edge", hwint, 6'h02);
        cyc();
        chk("edge_cleared", hwint, 0);
        chk("edge_any_off", irq_any, 0);
        wr(5'h00, 32'h0, 4'hF);
        wr(5'h04, 32'h0, 4'hF);

        // Masked capture
        wr(5'h04, 32'h04, 4'hF);
        irq_in = 6'h04;
        repeat (5) cyc();
        chk("mask_hwint", hwint, 0);
        rd(5'h08, "mask_pending", 32'h04);
        wr(5'h00, 32'h04, 4'hF);
        chk("mask_en_edge", hwint, 0);
        cyc();
        chk("mask_release", hwint, 6'h04);
        irq_in = 6'h00;
        wr(5'h08, 32'h04, 4'hF);
        wr(5'h00, 32'h0, 4'hF);
        wr(5'h04, 32'h0, 4'hF);
        repeat (3) cyc();

        // W1C colliding with a new rise
        wr(5'h04, 32'h08, 4'hF);
        irq_in = 6'h08;
        cyc(); cyc();
        irq_in = 6'h00;
        repeat (4) cyc();
        rd(5'h08, "coll_pre", 32'h08);
        irq_in = 6'h08;
        cyc(); cyc();
        wr(5'h08, 32'h08, 4'hF);
        rd(5'h08, "coll_kept", 32'h08);
        irq_in = 6'h00;
        repeat (4) cyc();
        wr(5'h08, 32'h08, 4'hF);
        rd(5'h08, "coll_plain_w1c", 32'h00);
        wr(5'h00, 32'h3F, 4'b0011);
        rd(5'h00, "partial_be", 32'h00);
        wr(5'h04, 32'h0, 4'hF);

        // Reset in the middle of activity
        wr(5'h04, 32'h3F, 4'hF);
        wr(5'h00, 32'h3F, 4'hF);
        irq_in = 6'h3F;
        repeat (4) cyc();
        chk("mid_pre_hwint", hwint, 6'h3F);
        chk("mid_pre_any", irq_any, 1);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        chk("mid_rst_hwint", hwint, 0);
        chk("mid_rst_any", irq_any, 0);
        chk("mid_rst_rdata", reg_rdata, 0);
        @(negedge clk);
        cyc(); cyc();
        reset = 1'b1;
        wr(5'h04, 32'h3F, 4'hF);
        reg_addr = 5'h0C;
        cyc();
        chk("post_raw_early", reg_rdata, 0);
        cyc();
        chk("post_raw", reg_rdata, 32'h3F);
        reg_addr = 5'h08;
        cyc();
        chk("post_pending", reg_rdata, 32'h3F);
        rd(5'h10, "post_unmapped", 0);
        chk("post_hwint", hwint, 0);

        // Randomised traffic against the reference model
        reset = 1'b0; irq_in = '0;
        model_clear();
        cyc();
        reset = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            logic [4:0] addrs [6];
            addrs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h02};
            if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ N'($urandom);
            reg_we     = ($urandom_range(0, 9) < 3);
            reg_addr   = addrs[$urandom_range(0, 5)];
            reg_byteen = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            reg_wdata  = $urandom;
            cyc();
            chk("rnd_hwint", hwint, m_hw);
            chk("rnd_any", irq_any, m_any);
            chk("rnd_rdata", reg_rdata, m_rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
